// File: rtl/video_fmt_pkg.sv
// video_fmt_pkg: pixel-format codes, register map and channel expand/pack helpers
// shared by the RGB format converter. Rev 1.0
`default_nettype none

package video_fmt_pkg;

  localparam logic [2:0] FMT_RGB565    = 3'd0;
  localparam logic [2:0] FMT_RGB888    = 3'd1;
  localparam logic [2:0] FMT_ARGB8888  = 3'd2;
  localparam logic [2:0] FMT_RGB101010 = 3'd3;
  localparam logic [2:0] FMT_ARGB10    = 3'd4;

  localparam logic [1:0] REG_STATUS      = 2'd0;
  localparam logic [1:0] REG_CONTROL     = 2'd1;
  localparam logic [1:0] REG_FRAME_COUNT = 2'd2;
  localparam logic [1:0] REG_LAST_PIXELS = 2'd3;

  typedef struct packed {
    logic [9:0] a;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } pix10_t;

  // MSB replication: the original bits become the top bits of the 10-bit value.
  function automatic logic [9:0] expand_to_10(input logic [9:0] v, input int unsigned w);
    logic [9:0] e;
    case (w)
      5:       e = {v[4:0], v[4:0]};
      6:       e = {v[5:0], v[5:2]};
      8:       e = {v[7:0], v[7:6]};
      default: e = v;
    endcase
    return e;
  endfunction

  function automatic pix10_t unpack_in(input logic [2:0] fmt, input logic [39:0] d,
                                       input logic [9:0] alpha);
    pix10_t p;
    p   = '0;
    p.a = alpha;
    case (fmt)
      FMT_RGB565: begin
        p.r = expand_to_10({5'd0, d[15:11]}, 5);
        p.g = expand_to_10({4'd0, d[10:5]}, 6);
        p.b = expand_to_10({5'd0, d[4:0]}, 5);
      end
      FMT_RGB888, FMT_ARGB8888: begin
        if (fmt == FMT_ARGB8888) p.a = expand_to_10({2'd0, d[31:24]}, 8);
        p.r = expand_to_10({2'd0, d[23:16]}, 8);
        p.g = expand_to_10({2'd0, d[15:8]}, 8);
        p.b = expand_to_10({2'd0, d[7:0]}, 8);
      end
      FMT_RGB101010: begin
        p.r = d[29:20];
        p.g = d[19:10];
        p.b = d[9:0];
      end
      default: begin
        p.a = d[39:30];
        p.r = d[29:20];
        p.g = d[19:10];
        p.b = d[9:0];
      end
    endcase
    return p;
  endfunction

  function automatic logic [39:0] pack_out(input logic [2:0] fmt, input pix10_t p);
    logic [39:0] d;
    case (fmt)
      FMT_RGB565:    d = {24'd0, p.r[9:5], p.g[9:4], p.b[9:5]};
      FMT_RGB888:    d = {16'd0, p.r[9:2], p.g[9:2], p.b[9:2]};
      FMT_ARGB8888:  d = {8'd0, p.a[9:2], p.r[9:2], p.g[9:2], p.b[9:2]};
      FMT_RGB101010: d = {10'd0, p.r, p.g, p.b};
      FMT_ARGB10:    d = {p.a, p.r, p.g, p.b};
      default:       d = '0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_st_skid_buffer.sv
// video_st_skid_buffer: two-entry Avalon-ST pipeline stage (output register plus
// one skid register) with a registered ready. Rev 1.0
`default_nettype none

module video_st_skid_buffer #(
  parameter int DW = 40,
  parameter int EW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [EW-1:0] in_empty,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic [EW-1:0] out_empty,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int PW = DW + EW + 2;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl_q, out_pl_d;
  logic [PW-1:0] skid_pl_q, skid_pl_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          accept;

  assign in_pl  = {in_data, in_sop, in_eop, in_empty};
  assign accept = in_valid && in_ready_q;

  // in_ready_q mirrors an empty skid register, so a beat is only ever accepted
  // when there is a free slot for it.
  always_comb begin
    out_pl_d     = out_pl_q;
    out_valid_d  = out_valid_q;
    skid_pl_d    = skid_pl_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_pl_d     = skid_pl_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_pl_d = in_pl;
      end
    end else if (accept) begin
      skid_pl_d    = in_pl;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_pl_q     <= '0;
      out_valid_q  <= 1'b0;
      skid_pl_q    <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_pl_q     <= out_pl_d;
      out_valid_q  <= out_valid_d;
      skid_pl_q    <= skid_pl_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign {out_data, out_sop, out_eop, out_empty} = out_pl_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: rtl/video_rgb_format_converter.sv
// video_rgb_format_converter: runtime-selectable RGB/ARGB pixel-format converter
// with Avalon-MM control/statistics and a skid-buffered Avalon-ST output. Rev 1.0
`default_nettype none

module video_rgb_format_converter
  import video_fmt_pkg::*;
#(
  parameter int         IDW             = 31,
  parameter int         ODW             = 39,
  parameter int         IEW             = 1,
  parameter int         OEW             = 1,
  parameter logic [2:0] DEFAULT_IN_FMT  = 3'd1,
  parameter logic [2:0] DEFAULT_OUT_FMT = 3'd3,
  parameter logic [9:0] ALPHA           = 10'h3FF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [IDW:0]   stream_in_data,
  input  logic           stream_in_startofpacket,
  input  logic           stream_in_endofpacket,
  input  logic [IEW:0]   stream_in_empty,
  input  logic           stream_in_valid,
  output logic           stream_in_ready,
  output logic [ODW:0]   stream_out_data,
  output logic           stream_out_startofpacket,
  output logic           stream_out_endofpacket,
  output logic [OEW:0]   stream_out_empty,
  output logic           stream_out_valid,
  input  logic           stream_out_ready,
  input  logic [1:0]     slave_address,
  input  logic           slave_read,
  input  logic           slave_write,
  input  logic [31:0]    slave_writedata,
  output logic [31:0]    slave_readdata
);

  typedef logic [ODW:0] odata_t;
  typedef logic [OEW:0] oempty_t;

  logic [2:0]  act_in_q, act_in_d, act_out_q, act_out_d;
  logic [2:0]  pend_in_q, pend_in_d, pend_out_q, pend_out_d;
  logic        pend_flag_q, pend_flag_d;
  logic        err_q, err_d;
  logic        in_pkt_q, in_pkt_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [31:0] last_pix_q, last_pix_d;
  logic [31:0] readdata_q, readdata_d;

  logic        accept, sop_acc, counted;
  logic [2:0]  eff_in, eff_out;
  logic [39:0] in40, conv40;
  logic [31:0] beat_cnt;
  logic        ctrl_ok;
  logic        unused_wdata;

  assign accept  = stream_in_valid && stream_in_ready;
  assign sop_acc = accept && stream_in_startofpacket;
  assign counted = accept && (stream_in_startofpacket || in_pkt_q);

  // An accepted SOP beat is already converted with the pending formats.
  assign eff_in  = sop_acc ? pend_in_q  : act_in_q;
  assign eff_out = sop_acc ? pend_out_q : act_out_q;

  assign in40   = 40'(stream_in_data);
  assign conv40 = (eff_in == eff_out) ? in40
                                      : pack_out(eff_out, unpack_in(eff_in, in40, ALPHA));

  assign beat_cnt = stream_in_startofpacket ? 32'd1
                  : ((pix_cnt_q == 32'hFFFF_FFFF) ? pix_cnt_q : pix_cnt_q + 32'd1);

  assign ctrl_ok      = (slave_writedata[2:0] <= FMT_ARGB10) && (slave_writedata[6:4] <= FMT_ARGB10);
  assign unused_wdata = ^{slave_writedata[31:7], slave_writedata[3]};

  always_comb begin
    act_in_d    = act_in_q;
    act_out_d   = act_out_q;
    pend_in_d   = pend_in_q;
    pend_out_d  = pend_out_q;
    pend_flag_d = pend_flag_q;
    err_d       = err_q;
    in_pkt_d    = in_pkt_q;
    frame_cnt_d = frame_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    last_pix_d  = last_pix_q;
    readdata_d  = readdata_q;

    if (sop_acc) begin
      act_in_d    = pend_in_q;
      act_out_d   = pend_out_q;
      pend_flag_d = 1'b0;
      in_pkt_d    = 1'b1;
    end

    if (counted) begin
      pix_cnt_d = beat_cnt;
      if (stream_in_endofpacket) begin
        in_pkt_d    = 1'b0;
        last_pix_d  = beat_cnt;
        frame_cnt_d = frame_cnt_q + 32'd1;
      end
    end

    // Bus writes come last so a same-cycle CONTROL write stays pending and a
    // FRAME_COUNT clear wins over an increment.
    if (slave_write) begin
      case (slave_address)
        REG_STATUS: err_d = 1'b0;
        REG_CONTROL: begin
          if (ctrl_ok) begin
            pend_in_d   = slave_writedata[2:0];
            pend_out_d  = slave_writedata[6:4];
            pend_flag_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        REG_FRAME_COUNT: frame_cnt_d = '0;
        default: ;
      endcase
    end

    if (slave_read) begin
      case (slave_address)
        REG_STATUS:      readdata_d = {err_q, 22'd0, pend_flag_q, 1'b0, act_out_q, 1'b0, act_in_q};
        REG_CONTROL:     readdata_d = {25'd0, pend_out_q, 1'b0, pend_in_q};
        REG_FRAME_COUNT: readdata_d = frame_cnt_q;
        default:         readdata_d = last_pix_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_in_q    <= DEFAULT_IN_FMT;
      act_out_q   <= DEFAULT_OUT_FMT;
      pend_in_q   <= DEFAULT_IN_FMT;
      pend_out_q  <= DEFAULT_OUT_FMT;
      pend_flag_q <= 1'b0;
      err_q       <= 1'b0;
      in_pkt_q    <= 1'b0;
      frame_cnt_q <= '0;
      pix_cnt_q   <= '0;
      last_pix_q  <= '0;
      readdata_q  <= '0;
    end else begin
      act_in_q    <= act_in_d;
      act_out_q   <= act_out_d;
      pend_in_q   <= pend_in_d;
      pend_out_q  <= pend_out_d;
      pend_flag_q <= pend_flag_d;
      err_q       <= err_d;
      in_pkt_q    <= in_pkt_d;
      frame_cnt_q <= frame_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      last_pix_q  <= last_pix_d;
      readdata_q  <= readdata_d;
    end
  end

  assign slave_readdata = readdata_q;

  video_st_skid_buffer #(
    .DW (ODW + 1),
    .EW (OEW + 1)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (odata_t'(conv40)),
    .in_sop    (stream_in_startofpacket),
    .in_eop    (stream_in_endofpacket),
    .in_empty  (oempty_t'(stream_in_empty)),
    .in_valid  (stream_in_valid),
    .in_ready  (stream_in_ready),
    .out_data  (stream_out_data),
    .out_sop   (stream_out_startofpacket),
    .out_eop   (stream_out_endofpacket),
    .out_empty (stream_out_empty),
    .out_valid (stream_out_valid),
    .out_ready (stream_out_ready)
  );

endmodule

`default_nettype wire
